scroll_v_controller: RTL and testbench
======================================

SCROLL_V_CONTROLLER -- requirements
Module: scroll_v_controller

Interface
REQ-001 SHALL have parameter PERIOD_INIT, default 1007000, meaning the initial move period in clk cycles (40 ms at 25.175 MHz).
REQ-002 SHALL have parameter PERIOD_MIN, default 503500, meaning the floor of the move period in cycles.
REQ-003 SHALL have parameter PERIOD_STEP, default 50350, meaning the period decrement per speed level.
REQ-004 SHALL have parameter RAMP_MOVES, default 64, meaning the number of moves between speed-level increments.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that (re)starts scrolling.
REQ-008 SHALL have port stop, input, 1 bit: a one-cycle pulse that halts scrolling (game over).
REQ-009 SHALL have port pause, input, 1 bit: a level that freezes scrolling while high.
REQ-010 SHALL have port frame_start, input, 1 bit: a one-cycle pulse at vblank start.
REQ-011 SHALL have port move, output, 1 bit: a one-cycle tick consumed by all vertical followers.
REQ-012 SHALL have port scroll_y, output, 10 bits: the master scroll offset, 0..479.
REQ-013 SHALL have port level, output, 4 bits: the current speed level, 0..15.
REQ-014 SHALL have port running, output, 1 bit: high in RUN.
REQ-015 SHALL have port overrun, output, 1 bit: sticky; a period expired while a move was already pending.

Function
REQ-016 SHALL implement states IDLE, RUN and PAUSE, with input priority stop > start > pause.
REQ-017 SHALL, in any state, on stop: go to IDLE, clear pending, hold scroll_y and level.
REQ-018 SHALL, in any state, on start: go to RUN with timer=0, period=PERIOD_INIT, level=0, scroll_y=0, move-count=0, pending=0, overrun=0.
REQ-019 SHALL, in RUN with pause=1, go to PAUSE; in PAUSE with pause=0, return to RUN.
REQ-020 SHALL, in RUN, increment the 20-bit timer each cycle; when timer==period-1, clear the timer and set pending.
REQ-021 SHALL, on an expiry while pending=1, keep pending set (no accumulation) and set overrun.
REQ-022 SHALL, in PAUSE and IDLE, freeze the timer and retain pending in PAUSE; move SHALL never assert outside RUN.
REQ-023 SHALL, on an edge where state=RUN, frame_start=1 and registered pending=1, assert move for exactly the next cycle and clear pending; the same edge SHALL update scroll_y.
REQ-024 SHALL carry an expiry that coincides with frame_start to the following frame_start.
REQ-025 SHALL update scroll_y as: if scroll_y+2 >= 480 then 0, else scroll_y+2 (the same rule as the followers).
REQ-026 SHALL, on every RAMP_MOVES-th move, set period = period-PERIOD_STEP if that result is >= PERIOD_MIN, else PERIOD_MIN; level increments, saturating at 15.
REQ-027 SHALL register all outputs; running = (state==RUN).

Reset
REQ-028 SHALL, on reset low, asynchronously force: state=IDLE, move=0, scroll_y=0, level=0, running=0, overrun=0, pending=0, timer=0, period=PERIOD_INIT, move-count=0.
REQ-029 SHALL, on reset asserted mid-RUN, discard any pending move; no move SHALL appear in the first cycle after release.

Structure
REQ-030 SHALL take SCREEN_HEIGHT=480, MOVE_AMT=2 and the state encoding from shared package scroll_pkg, which the followers SHALL also use.
REQ-031 SHALL place the period counter and expiry pulse in sub-module scroll_timer (inputs: enable, clear, period; output: expire).

Verification (PERIOD_INIT=10, PERIOD_MIN=4, PERIOD_STEP=3, RAMP_MOVES=2)
REQ-032 SHALL cover: start, then frame_start every 12 cycles -> one move per frame_start after each expiry; scroll_y 0,2,4,...
REQ-033 SHALL cover: 4 moves -> period 10->7->4 and level 0->1->2; the 6th move leaves period 4 (floor) and sets level 3.
REQ-034 SHALL cover: scroll_y=478, then a move -> scroll_y=0.
REQ-035 SHALL cover: two expiries with no frame_start -> overrun=1 and exactly one move at the next frame_start.
REQ-036 SHALL cover: pause high 50 cycles with pending=1 -> no move; timer frozen; move at the first frame_start after pause falls.
REQ-037 SHALL cover: start and stop in the same cycle -> IDLE; reset low mid-RUN with pending -> all outputs 0 and no move after release.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared constants for the vertical scroll master and its followers.
// Holds the playfield height, the per-move step, the scroll/timer widths,
// the controller state encoding and the scroll wrap rule, so every block
// that follows the master steps its own offset identically.
package scroll_pkg;

  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned MOVE_AMT      = 2;
  localparam int unsigned SCROLL_W      = 10;
  localparam int unsigned TIMER_W       = 20;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // One scroll step: wrap to zero once the next offset would reach the
  // bottom of the screen.
  function automatic logic [SCROLL_W-1:0] next_scroll(input logic [SCROLL_W-1:0] y);
    logic [SCROLL_W:0] sum;
    sum = {1'b0, y} + (SCROLL_W+1)'(MOVE_AMT);
    if (sum >= (SCROLL_W+1)'(SCREEN_HEIGHT)) begin
      return '0;
    end
    return sum[SCROLL_W-1:0];
  endfunction

endpackage

// File: rtl/scroll_timer.sv
// Move-period counter.
// Counts cycles while enabled and raises expire in the cycle the count
// reaches period-1; the count restarts from zero on that same edge.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   enable       - count this cycle (controller is actively running)
//   clear        - force the count back to zero (wins over enable)
//   period[19:0] - current move period in cycles
//   expire       - combinational expiry strobe for this cycle
module scroll_timer
  import scroll_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [TIMER_W-1:0] period,
  output logic               expire
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;
  logic [TIMER_W-1:0] last_count;

  // The period can shrink while a count is in flight; comparing with >=
  // makes an already-overshot count expire at once instead of running all
  // the way round the 20-bit range.
  assign last_count = (period == '0) ? '0 : period - TIMER_W'(1);
  assign expire     = enable && (count_q >= last_count);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = expire ? '0 : count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scroll_v_controller.sv
// Vertical scroll master.
// Generates the move tick shared by all vertical followers, the master
// scroll offset, and a speed ramp that shortens the move period every
// RAMP_MOVES moves down to PERIOD_MIN.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   start, stop     - one-cycle control pulses (stop > start > pause)
//   pause           - level; freezes scrolling while high
//   frame_start     - one-cycle pulse at vblank start
//   move            - one-cycle tick, only ever asserted while running
//   scroll_y[9:0]   - master scroll offset 0..479
//   level[3:0]      - speed level 0..15
//   running         - high while in RUN
//   overrun         - sticky: a period expired with a move still pending
//   state_dbg[1:0]  - current controller state, for checkers
// Handshake: move is a fire-and-forget tick; followers must consume it in
// the cycle it is high, there is no back-pressure.
module scroll_v_controller
  import scroll_pkg::*;
#(
  parameter int unsigned PERIOD_INIT = 1007000,
  parameter int unsigned PERIOD_MIN  = 503500,
  parameter int unsigned PERIOD_STEP = 50350,
  parameter int unsigned RAMP_MOVES  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                frame_start,
  output logic                move,
  output logic [SCROLL_W-1:0] scroll_y,
  output logic [3:0]          level,
  output logic                running,
  output logic                overrun,
  output logic [1:0]          state_dbg
);

  localparam int unsigned CNT_W = (RAMP_MOVES > 1) ? $clog2(RAMP_MOVES) : 1;
  localparam logic [TIMER_W-1:0] P_INIT = TIMER_W'(PERIOD_INIT);
  localparam logic [TIMER_W-1:0] P_MIN  = TIMER_W'(PERIOD_MIN);
  localparam logic [TIMER_W-1:0] P_STEP = TIMER_W'(PERIOD_STEP);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RAMP_MOVES - 1);

  logic [1:0]          state_q,   state_d;
  logic                pending_q, pending_d;
  logic [TIMER_W-1:0]  period_q,  period_d;
  logic [3:0]          level_q,   level_d;
  logic [SCROLL_W-1:0] scroll_q,  scroll_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                overrun_q, overrun_d;
  logic                move_q,    move_d;
  logic                running_q, running_d;

  logic tmr_en;
  logic tmr_clr;
  logic expire;
  logic fire;

  scroll_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (tmr_en),
    .clear  (tmr_clr),
    .period (period_q),
    .expire (expire)
  );

  assign fire = frame_start && pending_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    period_d  = period_q;
    level_d   = level_q;
    scroll_d  = scroll_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    move_d    = 1'b0;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;

    if (stop) begin
      state_d   = ST_IDLE;
      pending_d = 1'b0;
    end else if (start) begin
      state_d   = ST_RUN;
      pending_d = 1'b0;
      period_d  = P_INIT;
      level_d   = '0;
      scroll_d  = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
      tmr_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          // The edge that enters PAUSE is already frozen so that move can
          // never be high in a cycle where running is low.
          if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            tmr_en = 1'b1;
            if (fire) begin
              move_d   = 1'b1;
              scroll_d = next_scroll(scroll_q);
              if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                if ({1'b0, period_q} >= ({1'b0, P_MIN} + {1'b0, P_STEP})) begin
                  period_d = period_q - P_STEP;
                end else begin
                  period_d = P_MIN;
                end
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            // An expiry on the consuming edge re-arms pending for the next
            // frame; an expiry with an unconsumed move is an overrun.
            if (expire) begin
              pending_d = 1'b1;
              if (pending_q && !fire) begin
                overrun_d = 1'b1;
              end
            end else if (fire) begin
              pending_d = 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      period_q  <= P_INIT;
      level_q   <= '0;
      scroll_q  <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      move_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      period_q  <= period_d;
      level_q   <= level_d;
      scroll_q  <= scroll_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      move_q    <= move_d;
      running_q <= running_d;
    end
  end

  assign move      = move_q;
  assign scroll_y  = scroll_q;
  assign level     = level_q;
  assign running   = running_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_scroll_v_controller.sv
// Self-checking bench for scroll_v_controller with a small period setup.
module tb_scroll_v_controller;

  localparam int P_INIT = 10;
  localparam int P_MIN  = 4;
  localparam int P_STEP = 3;
  localparam int RAMP   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, stop = 1'b0, pause = 1'b0, frame_start = 1'b0;
  logic       move;
  logic [9:0] scroll_y;
  logic [3:0] level;
  logic       running;
  logic       overrun;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  scroll_v_controller #(
    .PERIOD_INIT (P_INIT),
    .PERIOD_MIN  (P_MIN),
    .PERIOD_STEP (P_STEP),
    .RAMP_MOVES  (RAMP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .frame_start (frame_start),
    .move        (move),
    .scroll_y    (scroll_y),
    .level       (level),
    .running     (running),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: active/paused flags, a cycle countdown toward the
  // next expiry, a latched "move owed" flag and a running total of moves.
  bit m_active, m_paused, m_pending, m_overrun, m_move;
  int m_timer, m_period, m_level, m_scroll, m_moves;
  logic [9:0] exp_q[$];
  int moves_seen;

  function automatic void model_reset();
    m_active = 0; m_paused = 0; m_pending = 0; m_overrun = 0; m_move = 0;
    m_timer = 0; m_period = P_INIT; m_level = 0; m_scroll = 0; m_moves = 0;
  endfunction

  function automatic void model_step(bit st, bit sp, bit ps, bit fs);
    bit fire, expd;
    m_move = 0;
    if (sp) begin
      m_active = 0; m_paused = 0; m_pending = 0;
    end else if (st) begin
      m_active = 1; m_paused = 0; m_pending = 0; m_overrun = 0;
      m_timer = 0; m_period = P_INIT; m_level = 0; m_scroll = 0; m_moves = 0;
    end else if (m_active && !m_paused && ps) begin
      m_paused = 1;
    end else if (m_active && m_paused) begin
      if (!ps) m_paused = 0;
    end else if (m_active) begin
      fire = fs && m_pending;
      expd = (m_timer >= m_period - 1);
      m_timer = expd ? 0 : m_timer + 1;
      if (fire) begin
        m_move = 1;
        m_scroll = (m_scroll + 2 >= 480) ? 0 : m_scroll + 2;
        m_moves++;
        if (m_moves % RAMP == 0) begin
          m_period = (m_period - P_STEP >= P_MIN) ? m_period - P_STEP : P_MIN;
          m_level  = (m_level < 15) ? m_level + 1 : 15;
        end
        exp_q.push_back(10'(m_scroll));
      end
      if (expd && m_pending && !fire) m_overrun = 1;
      if (expd) m_pending = 1;
      else if (fire) m_pending = 0;
    end
  endfunction

  // Scoreboard: every move the model predicts queues the scroll value the
  // DUT must show alongside its move tick.
  task automatic compare_outputs();
    check("move", 32'(move), 32'(m_move));
    check("scroll_y", 32'(scroll_y), 32'(m_scroll));
    check("level", 32'(level), 32'(m_level));
    check("running", 32'(running), 32'(m_active && !m_paused));
    check("overrun", 32'(overrun), 32'(m_overrun));
    if (move === 1'b1) begin
      moves_seen++;
      if (exp_q.size() == 0) check("sb_unexpected_move", 32'(1), 32'(0));
      else check("sb_scroll", 32'(scroll_y), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; applies inputs for the next edge.
  task automatic drive(input bit st, input bit sp, input bit ps, input bit fs);
    start = st; stop = sp; pause = ps; frame_start = fs;
    @(posedge clk);
    model_step(st, sp, ps, fs);
    #1;
    compare_outputs();
    start = 1'b0; stop = 1'b0; frame_start = 1'b0;
  endtask

  task automatic do_start();
    drive(1, 0, 0, 0);
    moves_seen = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev;
    bit done;
    int cnt;

    model_reset();
    moves_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_move", 32'(move), 0);
    check("rst_scroll", 32'(scroll_y), 0);
    check("rst_level", 32'(level), 0);
    check("rst_running", 32'(running), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b1;
    drive(0, 0, 0, 1);

    // Steady frames every 12 cycles: scroll_y climbs 2,4,6,...
    do_start();
    for (int i = 0; i < 60; i++) begin
      drive(0, 0, 0, (i % 12) == 11);
      if (move) check("seq_scroll", 32'(scroll_y), 32'(2 * moves_seen));
    end
    check("seq_moves_ge4", 32'(moves_seen >= 4), 1);

    // Speed ramp: six moves leave level 3 with the period at its floor.
    do_start();
    cnt = 0;
    while (moves_seen < 6 && cnt < 300) begin
      drive(0, 0, 0, (cnt % 12) == 11);
      if (move && moves_seen == 2) check("ramp_lvl1", 32'(level), 1);
      if (move && moves_seen == 4) check("ramp_lvl2", 32'(level), 2);
      cnt++;
    end
    check("ramp_6moves", 32'(moves_seen), 6);
    check("ramp_lvl3", 32'(level), 3);

    // Wrap: the move after 478 lands on 0.
    do_start();
    cnt = 0; done = 0; prev = 0;
    while (!done && cnt < 3000) begin
      drive(0, 0, 0, (cnt % 5) == 4);
      if (move) begin
        if (scroll_y == 0) begin
          check("wrap_prev478", 32'(prev), 478);
          done = 1;
        end
        prev = scroll_y;
      end
      cnt++;
    end
    check("wrap_reached", 32'(done), 1);

    // Overrun: two expiries without a frame, then exactly one move.
    do_start();
    repeat (25) drive(0, 0, 0, 0);
    check("ovr_sticky", 32'(overrun), 1);
    check("ovr_no_move", 32'(moves_seen), 0);
    drive(0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0);
    check("ovr_one_move", 32'(moves_seen), 1);

    // Pause with a move owed: nothing moves until pause falls.
    do_start();
    repeat (12) drive(0, 0, 0, 0);
    for (int i = 0; i < 50; i++) drive(0, 0, 1, (i % 7) == 6);
    check("pause_no_move", 32'(moves_seen), 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    check("pause_resume_move", 32'(move), 1);

    // start and stop together: stop wins.
    do_start();
    drive(1, 1, 0, 0);
    check("startstop_idle", 32'(running), 0);

    // Asynchronous reset mid-RUN with a move owed.
    do_start();
    repeat (12) drive(0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check("arst_move", 32'(move), 0);
    check("arst_scroll", 32'(scroll_y), 0);
    check("arst_level", 32'(level), 0);
    check("arst_running", 32'(running), 0);
    check("arst_overrun", 32'(overrun), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    moves_seen = 0;
    repeat (3) drive(0, 0, 0, 1);
    check("arst_no_move_after", 32'(moves_seen), 0);

    // Randomized traffic against the model.
    do_start();
    for (int i = 0; i < 2500; i++) begin
      bit st, sp, fs;
      bit ps;
      st = ($urandom_range(0, 199) == 0);
      sp = ($urandom_range(0, 299) == 0);
      fs = ($urandom_range(0, 5) == 0);
      ps = pause;
      if ($urandom_range(0, 39) == 0) ps = !pause;
      drive(st, sp, ps, fs);
    end
    drive(0, 0, 0, 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
